ocp_arbiter: RTL

OCP_ARBITER -- requirements
Module: ocp_arbiter

---
 rtl/ocp_arb_pkg.sv | 23 ++
 rtl/ocp_arb_rr.sv | 31 +++
 rtl/ocp_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ocp_arb_pkg.sv
// Shared encodings for the two-master OCP arbiter: command/response codes and FSM states.
package ocp_arb_pkg;

  localparam logic [2:0] MCMD_IDLE = 3'b000;
  localparam logic [2:0] MCMD_WR   = 3'b001;
  localparam logic [2:0] MCMD_RD   = 3'b010;

  localparam logic [1:0] SRESP_NULL = 2'b00;
  localparam logic [1:0] SRESP_DVA  = 2'b01;
  localparam logic [1:0] SRESP_ERR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // Only write and read start a transaction; every other code is ignored.
  function automatic logic cmd_valid(input logic [2:0] cmd);
    return (cmd == MCMD_WR) || (cmd == MCMD_RD);
  endfunction

endpackage

// File: rtl/ocp_arb_rr.sv
// Two-way round-robin grant decision; the pointer moves only when a transaction completes.
module ocp_arb_rr (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic [1:0] upd_owner,
  output logic [1:0] grant
);

  logic favour_m1;

  // After a completion the master that just finished loses priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      favour_m1 <= 1'b0;
    end else if (upd) begin
      favour_m1 <= (upd_owner == 2'b01);
    end
  end

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = favour_m1 ? 2'b10 : 2'b01;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/ocp_arbiter.sv
// Two-master to one-slave OCP arbiter with IDLE/CMD/RESP sequencing.
// Optional read-response timeout enabled by defining OCP_ARB_TIMEOUT_EN.
module ocp_arbiter
  import ocp_arb_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        m0_MCmd,
  input  logic [ADDR_W-1:0] m0_MAddr,
  input  logic [DATA_W-1:0] m0_MData,
  output logic              m0_SCmdAccept,
  output logic [DATA_W-1:0] m0_SData,
  output logic [1:0]        m0_SResp,
  input  logic [2:0]        m1_MCmd,
  input  logic [ADDR_W-1:0] m1_MAddr,
  input  logic [DATA_W-1:0] m1_MData,
  output logic              m1_SCmdAccept,
  output logic [DATA_W-1:0] m1_SData,
  output logic [1:0]        m1_SResp,
  output logic [2:0]        s_MCmd,
  output logic [ADDR_W-1:0] s_MAddr,
  output logic [DATA_W-1:0] s_MData,
  input  logic              s_SCmdAccept,
  input  logic [DATA_W-1:0] s_SData,
  input  logic [1:0]        s_SResp,
  output logic [1:0]        arb_grant,
  output logic [1:0]        dbg_state
);

  // Handshake: a master holds MCmd (with MAddr/MData) until it sees SCmdAccept
  // in the same cycle; the slave accepts by raising s_SCmdAccept while s_MCmd
  // is non-idle; a read completes in the first cycle s_SResp is non-null.

  arb_state_e        state, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        rr_grant;
  logic              rr_upd;
  logic              tmo_hit;
  logic [2:0]        own_cmd;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_data;
  logic              fwd_acc;
  logic [1:0]        fwd_resp;
  logic [DATA_W-1:0] fwd_data;

  ocp_arb_rr u_rr (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       ({cmd_valid(m1_MCmd), cmd_valid(m0_MCmd)}),
    .upd       (rr_upd),
    .upd_owner (grant_q),
    .grant     (rr_grant)
  );

`ifdef OCP_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);
  logic [7:0] tmo_cnt;

  // Zero on the first RESP cycle, so the last allowed cycle sees TMO_CYC-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= 8'd0;
    end else if (state != ST_RESP) begin
      tmo_cnt <= 8'd0;
    end else begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  assign tmo_hit = (state == ST_RESP) && (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      grant_q <= 2'b00;
    end else begin
      state   <= state_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    own_cmd  = grant_q[1] ? m1_MCmd  : m0_MCmd;
    own_addr = grant_q[1] ? m1_MAddr : m0_MAddr;
    own_data = grant_q[1] ? m1_MData : m0_MData;
  end

  always_comb begin
    state_d  = state;
    grant_d  = grant_q;
    rr_upd   = 1'b0;
    s_MCmd   = MCMD_IDLE;
    s_MAddr  = '0;
    s_MData  = '0;
    fwd_acc  = 1'b0;
    fwd_resp = SRESP_NULL;
    fwd_data = '0;
    case (state)
      ST_IDLE: begin
        if (rr_grant != 2'b00) begin
          grant_d = rr_grant;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        s_MCmd  = own_cmd;
        s_MAddr = own_addr;
        s_MData = own_data;
        if (!cmd_valid(own_cmd)) begin
          // Owner withdrew its command: release without moving the pointer.
          state_d = ST_IDLE;
          grant_d = 2'b00;
        end else if (s_SCmdAccept) begin
          fwd_acc = 1'b1;
          if (own_cmd == MCMD_WR) begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
            rr_upd  = 1'b1;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (s_SResp != SRESP_NULL) begin
          fwd_resp = s_SResp;
          fwd_data = s_SData;
          state_d  = ST_IDLE;
          grant_d  = 2'b00;
          rr_upd   = 1'b1;
        end else if (tmo_hit) begin
          fwd_resp = SRESP_ERR;
          state_d  = ST_IDLE;
          grant_d  = 2'b00;
          rr_upd   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  assign m0_SCmdAccept = fwd_acc & grant_q[0];
  assign m1_SCmdAccept = fwd_acc & grant_q[1];
  assign m0_SResp      = grant_q[0] ? fwd_resp : SRESP_NULL;
  assign m1_SResp      = grant_q[1] ? fwd_resp : SRESP_NULL;
  assign m0_SData      = grant_q[0] ? fwd_data : '0;
  assign m1_SData      = grant_q[1] ? fwd_data : '0;
  assign arb_grant     = grant_q;
  assign dbg_state     = state;

endmodule
